// File: rtl/muldiv_hilo_unit_if.sv
// Handshake and data bundle between the mult/div datapath and the HI/LO unit.
// The driver side of the datapath uses master; the unit itself uses slave.
interface muldiv_hilo_unit_if;
  logic        start_mult;
  logic        start_div;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic        div_done;
  logic        div_zero;
  logic        hi_wr;
  logic        lo_wr;
  logic [31:0] wr_data;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        div_zero_exc;
  logic        timeout_err;

  modport master (
    output start_mult, start_div,
    output mult_hi, mult_lo,
    output div_hi, div_lo,
    output div_done, div_zero,
    output hi_wr, lo_wr, wr_data,
    input  hi_out, lo_out,
    input  busy, done,
    input  div_zero_exc, timeout_err
  );

  modport slave (
    input  start_mult, start_div,
    input  mult_hi, mult_lo,
    input  div_hi, div_lo,
    input  div_done, div_zero,
    input  hi_wr, lo_wr, wr_data,
    output hi_out, lo_out,
    output busy, done,
    output div_zero_exc, timeout_err
  );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// HI/LO sequencer for the Booth multiplier and divider.
// Optional divider watchdog: define MULDIV_DIV_TIMEOUT_EN.
module muldiv_hilo_unit #(
  parameter int MULT_LAT    = 32,
  parameter int DIV_TIMEOUT = 40
) (
  input logic            clock,
  input logic            reset,
  muldiv_hilo_unit_if.slave bus
);

  localparam int CMAX = (MULT_LAT > DIV_TIMEOUT) ? MULT_LAT : DIV_TIMEOUT;
  localparam int CW   = $clog2(CMAX) + 1;

  typedef enum logic [1:0] {
    IDLE,
    MULT_WAIT,
    DIV_WAIT,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          exc_q, exc_d;
  logic          tmo_q, tmo_d;
  logic          div_ok;
  logic          div_bad;
  logic          div_tmo;
  logic          mult_cap;
  logic          wr_ok;

  assign mult_cap = (state_q == MULT_WAIT) && (cnt_q == '0);
  assign div_ok   = (state_q == DIV_WAIT) && bus.div_done && !bus.div_zero;
  assign div_bad  = (state_q == DIV_WAIT) && bus.div_done && bus.div_zero;
  assign wr_ok    = (state_q == IDLE) || (state_q == DONE);

`ifdef MULDIV_DIV_TIMEOUT_EN
  // A div_done on the timeout edge wins over the timeout.
  assign div_tmo = (state_q == DIV_WAIT) && !bus.div_done &&
                   (cnt_q == CW'(DIV_TIMEOUT - 1));
`else
  assign div_tmo = 1'b0;
`endif

  // State and counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and sequencing counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_mult) begin
          state_d = MULT_WAIT;
          cnt_d   = CW'(MULT_LAT - 1);
        end else if (bus.start_div) begin
          state_d = DIV_WAIT;
          cnt_d   = '0;
        end
      end
      MULT_WAIT: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DIV_WAIT: begin
        if (bus.div_done || div_tmo) begin
          state_d = DONE;
          cnt_d   = '0;
        end
`ifdef MULDIV_DIV_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered status and HI/LO update from captures and mthi/mtlo.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    busy_d = (state_d == MULT_WAIT) || (state_d == DIV_WAIT);
    done_d = (state_d == DONE);
    exc_d  = div_bad;
    tmo_d  = tmo_q | div_tmo;
    if (mult_cap) begin
      hi_d = bus.mult_hi;
      lo_d = bus.mult_lo;
    end
    if (div_ok) begin
      hi_d = bus.div_hi;
      lo_d = bus.div_lo;
    end
    if (wr_ok && bus.hi_wr) hi_d = bus.wr_data;
    if (wr_ok && bus.lo_wr) lo_d = bus.wr_data;
  end

  // Output and architectural register flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      exc_q  <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      busy_q <= busy_d;
      done_q <= done_d;
      exc_q  <= exc_d;
      tmo_q  <= tmo_d;
    end
  end

  assign bus.hi_out       = hi_q;
  assign bus.lo_out       = lo_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.div_zero_exc = exc_q;
`ifdef MULDIV_DIV_TIMEOUT_EN
  assign bus.timeout_err  = tmo_q;
`else
  assign bus.timeout_err  = 1'b0;
`endif

endmodule
